// File: rtl/instr_prefetch_if.sv
// Fetch-side bus bundle: instruction memory request/response, core instruction
// handshake and redirect. master = prefetch unit, slave = memory/core environment.
interface instr_prefetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_valid, instr, instr_pc,
      input  instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_valid, instr, instr_pc,
      output instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch: credit-limited fetch, in-order response FIFO, redirect flush.
// Define PREFETCH_BYPASS_EN to present a response straight to the core when the FIFO is empty.
module instr_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic              clk,
   input logic              rst,
   instr_prefetch_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   pc_q [DEPTH];

   logic [CW:0]   used;
   logic          fifo_valid;
   logic          req_fire;
   logic          rsp_ok;
   logic          keep;
   logic          push;
   logic          pop;
   logic          bypass;

   // Credit covers buffered words plus every accepted request, including ones to be discarded.
   assign used       = {1'b0, occ_q} + {1'b0, outst_q};
   assign fifo_valid = (occ_q != '0);
   assign rsp_ok     = bus.imem_rsp_valid && (outst_q != '0);
   assign keep       = rsp_ok && (state_q == RUN) && !bus.redirect_valid;

   assign bus.imem_req_valid = !rst && (used < (CW+1)'(DEPTH)) && !bus.redirect_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

`ifdef PREFETCH_BYPASS_EN
   assign bypass = !fifo_valid && keep;
`else
   assign bypass = 1'b0;
`endif

   assign bus.instr_valid = fifo_valid || bypass;
   assign bus.instr       = fifo_valid ? data_q[rd_ptr_q] : (bypass ? bus.imem_rsp_data : 32'h0);
   assign bus.instr_pc    = fifo_valid ? pc_q[rd_ptr_q]   : (bypass ? rsp_pc_q : 32'h0);

   assign pop  = fifo_valid && bus.instr_ready;
   // A bypassed word taken by the core in the same cycle never enters the FIFO.
   assign push = keep && !(bypass && bus.instr_ready);

   always_comb begin
      outst_d    = outst_q + CW'(req_fire) - CW'(rsp_ok);
      occ_d      = occ_q + CW'(push) - CW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      fetch_pc_d = fetch_pc_q + 32'(req_fire);
      rsp_pc_d   = rsp_pc_q + 32'(keep);
      discard_d  = discard_q;
      if (rsp_ok && (state_q == DRAIN)) begin
         discard_d = discard_q - CW'(1);
      end
      if (bus.redirect_valid) begin
         occ_d      = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fetch_pc_d = bus.redirect_pc;
         rsp_pc_d   = bus.redirect_pc;
         discard_d  = outst_d;
      end
      state_d = (discard_d != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         occ_q      <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
      end
   end

   // Payload storage needs no reset: occupancy gates everything read from it.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= bus.imem_rsp_data;
         pc_q[wr_ptr_q]   <= rsp_pc_q;
      end
   end
endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: in-order memory model with variable latency,
// expected PC/word queue filled on request acceptance and drained on core pops.
module tb_instr_prefetch;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef PREFETCH_BYPASS_EN
   localparam logic BYP_EXP = 1'b1;
`else
   localparam logic BYP_EXP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   instr_prefetch_if bus();

   instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          cyc_since_rst = 0;
   int          lat = 1;
   int          n_pops = 0;
   int          n_req = 0;
   bit          probe_en = 1'b0;
   logic [31:0] exp_fetch = RESET_PC;
   exp_t        expq[$];
   mreq_t       memq[$];
   logic [31:0] popped[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a << 7) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock cycle: observe at negedge, advance memory model after posedge.
   task automatic cycle();
      logic        fire;
      logic [31:0] fire_addr;
      exp_t        e;
      mreq_t       m;
      @(negedge clk);
      if (probe_en) begin
         if (cyc_since_rst == 0) chk("first_req_after_reset", 32'(bus.imem_req_valid), 32'd1);
         if (cyc_since_rst == 1) begin
            chk("valid_in_response_cycle", 32'(bus.instr_valid), 32'(BYP_EXP));
            chk("word_in_response_cycle", bus.instr, BYP_EXP ? 32'h13 : 32'h0);
         end
         if (cyc_since_rst == 2) chk("valid_after_response", 32'(bus.instr_valid), 32'd1);
      end
      if (bus.instr_valid && bus.instr_ready) begin
         n_pops++;
         popped.push_back(bus.instr_pc);
         $display("pop pc=%h instr=%h", bus.instr_pc, bus.instr);
         if (expq.size() == 0) begin
            chk("spurious_pop", 32'(bus.instr_valid), 32'd0);
         end else begin
            e = expq.pop_front();
            chk("instr_pc", bus.instr_pc, e.pc);
            chk("instr_word", bus.instr, e.data);
         end
      end
      if (!bus.instr_valid) chk("idle_outputs_zero", bus.instr | bus.instr_pc, 32'd0);
      if (bus.redirect_valid) begin
         chk("req_blocked_by_redirect", 32'(bus.imem_req_valid), 32'd0);
         expq.delete();
         exp_fetch = bus.redirect_pc;
      end
      fire      = bus.imem_req_valid && bus.imem_req_ready;
      fire_addr = bus.imem_req_addr;
      if (fire) begin
         n_req++;
         chk("req_addr", fire_addr, exp_fetch);
         expq.push_back('{pc: exp_fetch, data: mem_word(exp_fetch)});
         exp_fetch = exp_fetch + 32'd1;
      end
      @(posedge clk);
      cyc++;
      cyc_since_rst++;
      if (fire) memq.push_back('{addr: fire_addr, due: cyc + lat - 1});
      #1;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         m = memq.pop_front();
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(m.addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'h0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("async_reset_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("async_reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      memq.delete();
      expq.delete();
      exp_fetch = RESET_PC;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_addr", bus.imem_req_addr, RESET_PC);
      chk("reset_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("reset_instr", bus.instr, 32'd0);
      chk("reset_instr_pc", bus.instr_pc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      cyc_since_rst = 0;
   endtask

   initial begin
      int base;
      int base2;
      bit found;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;

      // Streaming with 1-cycle memory, core always ready.
      do_reset();
      lat = 1;
      probe_en = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      repeat (3) cycle();
      probe_en = 1'b0;
      base = n_pops;
      repeat (20) cycle();
      chk("stream_throughput", 32'(n_pops - base), 32'd20);

      // Core stalled: credit limits requests to DEPTH.
      do_reset();
      lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b0;
      n_req = 0;
      repeat (10) cycle();
      chk("stall_request_count", 32'(n_req), 32'(DEPTH));
      chk("stall_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
      chk("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_head_pc", bus.instr_pc, 32'd0);
      bus.instr_ready = 1'b1;
      base = popped.size();
      repeat (10) cycle();
      if (popped.size() >= base + 4) begin
         for (int i = 0; i < 4; i++) chk("stall_release_order", popped[base+i], 32'(i));
      end else begin
         chk("stall_release_pops", 32'(popped.size() - base), 32'd4);
      end

      // 3-cycle memory, redirect with two responses still pending.
      do_reset();
      lat = 3;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         if (i >= 6 && memq.size() == 2) begin
            found = 1'b1;
         end else begin
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            cycle();
         end
      end
      chk("redirect_window_found", 32'(found), 32'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      cycle();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      base2 = popped.size();
      repeat (20) cycle();
      if (popped.size() > base2) chk("redirect_first_pc", popped[base2], 32'h40);
      else chk("redirect_pops", 32'(popped.size() - base2), 32'd1);

      // Redirect in the same cycle the core pops PC 5.
      do_reset();
      lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.instr_valid && bus.instr_pc == 32'd5) found = 1'b1;
         else cycle();
      end
      chk("pc5_reached", 32'(found), 32'd1);
      bus.instr_ready = 1'b0;
      repeat (3) cycle();
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      base = popped.size();
      cycle();
      bus.redirect_valid = 1'b0;
      repeat (10) cycle();
      if (popped.size() >= base + 2) begin
         chk("pop_with_redirect_pc", popped[base], 32'd5);
         chk("after_pop_redirect_pc", popped[base+1], 32'h100);
      end else begin
         chk("pop_redirect_pops", 32'(popped.size() - base), 32'd2);
      end

      // Address wrap with randomly stalling memory.
      do_reset();
      lat = 2;
      bus.instr_ready    = 1'b1;
      bus.imem_req_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFE;
      cycle();
      bus.redirect_valid = 1'b0;
      base = popped.size();
      for (int i = 0; i < 100 && popped.size() < base + 6; i++) begin
         bus.imem_req_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      if (popped.size() >= base + 4) begin
         chk("wrap_pc0", popped[base],   32'hFFFF_FFFE);
         chk("wrap_pc1", popped[base+1], 32'hFFFF_FFFF);
         chk("wrap_pc2", popped[base+2], 32'h0000_0000);
         chk("wrap_pc3", popped[base+3], 32'h0000_0001);
      end else begin
         chk("wrap_pops", 32'(popped.size() - base), 32'd4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
